// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered fetch program-counter sequencer with branch redirect (optional PC_ALIGN_CHK_EN)
module pc_sequencer #(
  parameter int          ADDR_W   = 64,
  parameter int          COND_W   = 19,
  parameter int          UNCOND_W = 26,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                fetch_valid,
  input  logic                fetch_ready,
  output logic [ADDR_W-1:0]   fetch_pc,
  input  logic                ex_branch_vld,
  input  logic                ex_taken,
  input  logic [ADDR_W-1:0]   ex_pc,
  input  logic                ex_uncond_br,
  input  logic [COND_W-1:0]   ex_cond_off,
  input  logic [UNCOND_W-1:0] ex_uncond_off,
  input  logic                ex_br_reg,
  input  logic [ADDR_W-1:0]   ex_reg_target,
  output logic                redirect,
  output logic                align_fault
);

  localparam logic [ADDR_W-1:0] RST_PC  = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
`ifdef PC_ALIGN_CHK_EN
  localparam logic [1:0] ST_FAULT = 2'd2;
`else
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
`endif

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ADDR_W-1:0] pc_d;
  logic              redirect_d;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] off_bytes;
  logic [ADDR_W-1:0] tgt;
  logic              take;
  logic              accept;

  // Word offsets are sign-extended to full width, then scaled to bytes.
  assign off_ext   = ex_uncond_br ?
                     {{(ADDR_W-UNCOND_W){ex_uncond_off[UNCOND_W-1]}}, ex_uncond_off} :
                     {{(ADDR_W-COND_W){ex_cond_off[COND_W-1]}}, ex_cond_off};
  assign off_bytes = off_ext << 2;
  assign tgt       = ex_br_reg ? ex_reg_target : (ex_pc + off_bytes);

  assign take        = ex_branch_vld & ex_taken;
  assign fetch_valid = (state_q == ST_RUN);
  assign accept      = fetch_valid & fetch_ready;

`ifdef PC_ALIGN_CHK_EN
  logic fault_q;
  logic fault_d;
  assign align_fault = fault_q;
`else
  assign align_fault = 1'b0;
`endif

  // Next-state selection: a taken branch beats a sequential accept, which beats hold.
  always_comb begin
    state_d    = state_q;
    pc_d       = fetch_pc;
    redirect_d = 1'b0;
`ifdef PC_ALIGN_CHK_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      ST_BOOT, ST_RUN: begin
        state_d = ST_RUN;
        if (take) begin
          redirect_d = 1'b1;
`ifdef PC_ALIGN_CHK_EN
          // Misaligned target is still loaded so debug can see where it pointed.
          pc_d = tgt;
          if (tgt[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end
`else
          pc_d = tgt & ALIGN_MASK;
`endif
        end else if (accept) begin
          pc_d = fetch_pc + PC_STEP;
        end
      end
`ifdef PC_ALIGN_CHK_EN
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
`endif
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Architectural PC, FSM and redirect pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_BOOT;
      fetch_pc <= RST_PC;
      redirect <= 1'b0;
    end else begin
      state_q  <= state_d;
      fetch_pc <= pc_d;
      redirect <= redirect_d;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

endmodule
